serial_add_ctrl: RTL and testbench

- Bit-serial adder controller. Sequences one shared `fa` full-adder instance (ports a, b, cin, s, cout) over WIDTH clock cycles to add two WIDTH-bit operands, LSB first.
- Input and output use valid/ready handshakes.
- Used where area matters more than latency. Becomes the standard way the team reuses the 1-bit `fa` cell for multi-bit arithmetic.

---
 rtl/serial_add_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared 1-bit full adder stepped over WIDTH cycles, LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds an in_sub port for A-B via inverted B and carry-in 1.

module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             in_sub,
`endif
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic [1:0]       o_dbg_state
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_out_sum;
   logic             r_out_cout;
   logic             r_out_ovf;

   logic             w_s;
   logic             w_cout;
   logic [WIDTH-1:0] w_sum_next;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;

   // Handshakes: a transfer happens on a rising edge where valid && ready; in_ready and
   // out_valid decode registered state only (in_ready is also masked by rst).
   assign in_ready    = !rst && (r_state == S_IDLE);
   assign out_valid   = (r_state == S_DONE);
   assign busy        = (r_state == S_RUN);
   assign out_sum     = r_out_sum;
   assign out_cout    = r_out_cout;
   assign out_ovf     = r_out_ovf;
   assign o_dbg_state = r_state;

`ifdef SERIAL_ADD_SUB_EN
   assign w_b_load = in_sub ? ~in_b : in_b;
   assign w_c_load = in_sub ? 1'b1 : in_cin;
`else
   assign w_b_load = in_b;
   assign w_c_load = in_cin;
`endif

   fa u_fa (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
   );

   // Only sum_sh[WIDTH-1:1] is ever observed, so only those bits are stored.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_sum_next = w_s;
      end else begin : g_wn
         logic [WIDTH-2:0] r_sum_hi;
         assign w_sum_next = {w_s, r_sum_hi};
         always_ff @(posedge clk) begin
            if (rst) begin
               r_sum_hi <= '0;
            end else if (r_state == S_RUN) begin
               r_sum_hi <= w_sum_next[WIDTH-1:1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_a_sh     <= '0;
         r_b_sh     <= '0;
         r_carry    <= 1'b0;
         r_cnt      <= '0;
         r_out_sum  <= '0;
         r_out_cout <= 1'b0;
         r_out_ovf  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a_sh  <= in_a;
                  r_b_sh  <= w_b_load;
                  r_carry <= w_c_load;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_out_sum  <= w_sum_next;
                  r_out_cout <= w_cout;
                  // r_carry is the carry into the MSB on this final step
                  r_out_ovf  <= r_carry ^ w_cout;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 with a result queue.

module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       in_valid8 = 1'b0, in_cin8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b0;
   logic [7:0] in_a8 = '0, in_b8 = '0;
   logic       in_ready8, busy8, out_valid8, out_cout8, out_ovf8;
   logic [7:0] out_sum8;
   logic [1:0] dbg8;

   logic       in_valid1 = 1'b0, in_cin1 = 1'b0, sub1 = 1'b0, out_ready1 = 1'b0;
   logic [0:0] in_a1 = '0, in_b1 = '0;
   logic       in_ready1, busy1, out_valid1, out_cout1, out_ovf1;
   logic [0:0] out_sum1;
   logic [1:0] dbg1;

   logic [9:0] exp_q[$];
   logic [2:0] exp1_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_a(in_a8), .in_b(in_b8), .in_cin(in_cin8),
`ifdef SERIAL_ADD_SUB_EN
      .in_sub(sub8),
`endif
      .busy(busy8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out_sum(out_sum8), .out_cout(out_cout8), .out_ovf(out_ovf8), .o_dbg_state(dbg8)
   );

   serial_add_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
`ifdef SERIAL_ADD_SUB_EN
      .in_sub(sub1),
`endif
      .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1), .o_dbg_state(dbg1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {cout, ovf, sum} for an 8-bit add, or A-B when sub is set
   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
      logic [7:0] be;
      logic       ce;
      logic [8:0] full;
      logic [7:0] low;
      be   = sub ? ~b : b;
      ce   = sub ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, be} + {8'd0, ce};
      low  = {1'b0, a[6:0]} + {1'b0, be[6:0]} + {7'd0, ce};
      return {full[8], full[8] ^ low[7], full[7:0]};
   endfunction

   task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input int hold, input bit mid_change);
      int lat;
      logic [9:0] exp;
      @(negedge clk);
      check("in_ready8_idle", in_ready8, 1'b1);
      in_a8 = a; in_b8 = b; in_cin8 = cin; sub8 = sub; in_valid8 = 1'b1;
      exp_q.push_back(model8(a, b, cin, sub));
      @(negedge clk);
      in_valid8 = 1'b0;
      check("busy8_run", busy8, 1'b1);
      check("in_ready8_run", in_ready8, 1'b0);
      lat = 0;
      while (out_valid8 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
         if (mid_change && lat == 2) begin
            in_a8 = 8'hAA; in_b8 = 8'h55; in_cin8 = 1'b1; in_valid8 = 1'b1;
         end
      end
      in_valid8 = 1'b0;
      check("latency8", lat, 8);
      if (exp_q.size() == 0) begin
         check("queue8_nonempty", 0, 1);
         exp = '0;
      end else begin
         exp = exp_q.pop_front();
      end
      check("result8", {out_cout8, out_ovf8, out_sum8}, exp);
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            in_valid8 = 1'b1; in_a8 = 8'h12;
         end
         @(negedge clk);
         in_valid8 = 1'b0;
         check("hold_valid", out_valid8, 1'b1);
         check("hold_result", {out_cout8, out_ovf8, out_sum8}, exp);
         check("hold_in_ready", in_ready8, 1'b0);
      end
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      check("after_hs_state", dbg8, 2'd0);
      check("after_hs_valid", out_valid8, 1'b0);
      check("after_hs_keep", {out_cout8, out_ovf8, out_sum8}, exp);
   endtask

   task automatic do_op1(input logic a, input logic b, input logic cin);
      int lat;
      logic [1:0] full;
      logic [2:0] exp;
      @(negedge clk);
      check("in_ready1_idle", in_ready1, 1'b1);
      in_a1 = a; in_b1 = b; in_cin1 = cin; in_valid1 = 1'b1;
      full = {1'b0, a} + {1'b0, b} + {1'b0, cin};
      exp1_q.push_back({full[1], full[1] ^ cin, full[0]});
      @(negedge clk);
      in_valid1 = 1'b0;
      check("busy1_run", busy1, 1'b1);
      lat = 0;
      while (out_valid1 !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("latency1", lat, 1);
      if (exp1_q.size() == 0) begin
         check("queue1_nonempty", 0, 1);
         exp = '0;
      end else begin
         exp = exp1_q.pop_front();
      end
      check("result1", {out_cout1, out_ovf1, out_sum1}, exp);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      check("after_hs1_state", dbg1, 2'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready8, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid8, 1'b0);
      check("rst_sum", out_sum8, 8'h00);
      check("rst_cout", out_cout8, 1'b0);
      check("rst_ovf", out_ovf8, 1'b0);
      check("rst_busy", busy8, 1'b0);
      check("rst_state", dbg8, 2'd0);
      check("rst_in_ready_after", in_ready8, 1'b1);

      // WIDTH=1 full-adder truth table
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         do_op1(v[2], v[1], v[0]);
      end

      // carry wrap and signed overflow
      do_op8(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
      do_op8(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0);

      // backpressure in DONE with an ignored in_valid pulse, then 12+34
      do_op8(8'h55, 8'h22, 1'b0, 1'b0, 5, 1'b0);
      do_op8(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0);

      // operand change during RUN has no effect
      do_op8(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b1);

      // reset in the middle of RUN
      @(negedge clk);
      in_a8 = 8'h99; in_b8 = 8'h11; in_cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_busy_before", busy8, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", out_valid8, 1'b0);
      check("mid_rst_sum", out_sum8, 8'h00);
      check("mid_rst_cout", out_cout8, 1'b0);
      check("mid_rst_busy", busy8, 1'b0);
      check("mid_rst_in_ready", in_ready8, 1'b0);
      rst = 1'b0;
      #1;
      check("mid_rst_ready_after", in_ready8, 1'b1);
      do_op8(8'h03, 8'h04, 1'b1, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      do_op8(8'h05, 8'h07, 1'b1, 1'b1, 0, 1'b0);
      do_op8(8'h07, 8'h05, 1'b0, 1'b1, 0, 1'b0);
      do_op8(8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b0);
`endif

      // random operands
      for (int i = 0; i < 10; i++) begin
         do_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2), 1'b0);
      end

      check("queue8_drained", exp_q.size(), 0);
      check("queue1_drained", exp1_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
